// File: rtl/txt_console_writer.sv
// Character-stream writer for the 40x30 text screen RAM: cursor tracking, CR/LF/BS/FF handling.
// Optional blinking-free cursor glyph enabled by defining TXT_CURSOR_EN.
module txt_console_writer #(
`ifdef TXT_CURSOR_EN
   parameter logic [7:0]  CURSOR_CHAR = 8'h5F,
`endif
   parameter int unsigned COLS        = 40,
   parameter int unsigned ROWS        = 30,
   parameter int unsigned COL_BITS    = 6,
   parameter int unsigned ROW_BITS    = 5,
   parameter logic [7:0]  CLEAR_CHAR  = 8'h20
) (
   input  logic                i_pixel_clock,
   input  logic                i_reset_n,
   input  logic                i_ch_valid,
   input  logic [7:0]          i_ch_data,
   output logic                o_ch_ready,
   input  logic [2:0]          i_fcolor,
   input  logic [2:0]          i_bcolor,
   input  logic                i_set_pos,
   input  logic [ROW_BITS-1:0] i_pos_row,
   input  logic [COL_BITS-1:0] i_pos_col,
   output logic [ROW_BITS-1:0] o_cur_row,
   output logic [COL_BITS-1:0] o_cur_col,
   output logic [15:0]         o_wrdata,
   output logic [12:0]         o_wradr,
   output logic                o_wren
);

   localparam logic [ROW_BITS-1:0] LastRow = ROW_BITS'(ROWS - 1);
   localparam logic [COL_BITS-1:0] LastCol = COL_BITS'(COLS - 1);

   typedef enum logic [1:0] {StIdle, StClear, StCursor} state_e;

   state_e              r_state, w_state_d;
   logic [ROW_BITS-1:0] r_row, w_row_d, w_row_e;
   logic [COL_BITS-1:0] r_col, w_col_d, w_col_e;
   logic                r_wren, w_wren_d;
   logic [12:0]         r_wradr, w_wradr_d;
   logic [15:0]         r_wrdata, w_wrdata_d;
   logic                w_accept;

   function automatic logic [12:0] f_adr(input logic [ROW_BITS-1:0] row,
                                         input logic [COL_BITS-1:0] col);
      return {{(13 - ROW_BITS - COL_BITS){1'b0}}, row, col};
   endfunction

   function automatic logic [15:0] f_word(input logic [2:0] bc, input logic [2:0] fc,
                                          input logic [7:0] ch);
      return {1'b0, bc, 1'b0, fc, ch};
   endfunction

   assign o_ch_ready = (r_state == StIdle) && i_reset_n;
   assign w_accept   = i_ch_valid && o_ch_ready;
   assign o_cur_row  = r_row;
   assign o_cur_col  = r_col;
   assign o_wren     = r_wren;
   assign o_wradr    = r_wradr;
   assign o_wrdata   = r_wrdata;

   // Effective cursor in the idle cycle: a coincident set_pos is applied before the byte.
   assign w_row_e = !i_set_pos ? r_row : ((i_pos_row > LastRow) ? LastRow : i_pos_row);
   assign w_col_e = !i_set_pos ? r_col : ((i_pos_col > LastCol) ? LastCol : i_pos_col);

`ifdef TXT_CURSOR_EN
   logic [2:0] r_fc, r_bc;

   always_ff @(posedge i_pixel_clock) begin
      if (!i_reset_n) begin
         r_fc <= '0;
         r_bc <= '0;
      end else if (r_state != StCursor) begin
         r_fc <= i_fcolor;
         r_bc <= i_bcolor;
      end
   end
`endif

   always_comb begin
      w_state_d  = r_state;
      w_row_d    = r_row;
      w_col_d    = r_col;
      w_wren_d   = 1'b0;
      w_wradr_d  = r_wradr;
      w_wrdata_d = r_wrdata;
      unique case (r_state)
         StIdle: begin
            w_row_d = w_row_e;
            w_col_d = w_col_e;
            if (w_accept) begin
               case (i_ch_data)
                  8'h0D: w_col_d = '0;
                  8'h0A: begin
                     w_col_d = '0;
                     w_row_d = (w_row_e == LastRow) ? '0 : w_row_e + 1'b1;
                  end
                  8'h08: begin
                     if (w_col_e != '0) begin
                        w_col_d = w_col_e - 1'b1;
                     end else if (w_row_e != '0) begin
                        w_row_d = w_row_e - 1'b1;
                        w_col_d = LastCol;
                     end
                     w_wren_d   = 1'b1;
                     w_wradr_d  = f_adr(w_row_d, w_col_d);
                     w_wrdata_d = f_word(i_bcolor, i_fcolor, CLEAR_CHAR);
                  end
                  8'h0C: begin
                     // The clear sweep reuses the cursor registers, ending at (0,0).
                     w_state_d = StClear;
                     w_row_d   = '0;
                     w_col_d   = '0;
                  end
                  default: begin
                     w_wren_d   = 1'b1;
                     w_wradr_d  = f_adr(w_row_e, w_col_e);
                     w_wrdata_d = f_word(i_bcolor, i_fcolor, i_ch_data);
                     if (w_col_e == LastCol) begin
                        w_col_d = '0;
                        w_row_d = (w_row_e == LastRow) ? '0 : w_row_e + 1'b1;
                     end else begin
                        w_col_d = w_col_e + 1'b1;
                     end
                  end
               endcase
            end
`ifdef TXT_CURSOR_EN
            if (w_state_d == StIdle && (w_accept || i_set_pos)) begin
               w_state_d = StCursor;
               // Erase the old cursor glyph when nothing else is written this cycle.
               if (!w_wren_d) begin
                  w_wren_d   = 1'b1;
                  w_wradr_d  = f_adr(r_row, r_col);
                  w_wrdata_d = f_word(i_bcolor, i_fcolor, CLEAR_CHAR);
               end
            end
`endif
         end
         StClear: begin
            w_wren_d   = 1'b1;
            w_wradr_d  = f_adr(r_row, r_col);
            w_wrdata_d = f_word(i_bcolor, i_fcolor, CLEAR_CHAR);
            if (r_col == LastCol) begin
               w_col_d = '0;
               if (r_row == LastRow) begin
                  w_row_d = '0;
`ifdef TXT_CURSOR_EN
                  w_state_d = StCursor;
`else
                  w_state_d = StIdle;
`endif
               end else begin
                  w_row_d = r_row + 1'b1;
               end
            end else begin
               w_col_d = r_col + 1'b1;
            end
         end
`ifdef TXT_CURSOR_EN
         StCursor: begin
            w_wren_d   = 1'b1;
            w_wradr_d  = f_adr(r_row, r_col);
            w_wrdata_d = f_word(r_bc, r_fc, CURSOR_CHAR);
            w_state_d  = StIdle;
         end
`endif
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_pixel_clock) begin
      if (!i_reset_n) begin
         r_state  <= StClear;
         r_row    <= '0;
         r_col    <= '0;
         r_wren   <= 1'b0;
         r_wradr  <= '0;
         r_wrdata <= '0;
      end else begin
         r_state  <= w_state_d;
         r_row    <= w_row_d;
         r_col    <= w_col_d;
         r_wren   <= w_wren_d;
         r_wradr  <= w_wradr_d;
         r_wrdata <= w_wrdata_d;
      end
   end

endmodule

// File: tb/tb_txt_console_writer.sv
// Scoreboard bench for txt_console_writer: a linear-cursor reference model predicts every
// screen write; a negedge monitor pops and compares each write the DUT issues.
module tb_txt_console_writer;

   localparam int COLS  = 40;
   localparam int ROWS  = 30;
   localparam int CELLS = COLS * ROWS;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ch_valid = 1'b0;
   logic [7:0]  ch_data = '0;
   logic        ch_ready;
   logic [2:0]  fcolor = '0;
   logic [2:0]  bcolor = '0;
   logic        set_pos = 1'b0;
   logic [4:0]  pos_row = '0;
   logic [5:0]  pos_col = '0;
   logic [4:0]  cur_row;
   logic [5:0]  cur_col;
   logic [15:0] wrdata;
   logic [12:0] wradr;
   logic        wren;

   always #5 clk = ~clk;

   txt_console_writer dut (
      .i_pixel_clock (clk),
      .i_reset_n     (reset_n),
      .i_ch_valid    (ch_valid),
      .i_ch_data     (ch_data),
      .o_ch_ready    (ch_ready),
      .i_fcolor      (fcolor),
      .i_bcolor      (bcolor),
      .i_set_pos     (set_pos),
      .i_pos_row     (pos_row),
      .i_pos_col     (pos_col),
      .o_cur_row     (cur_row),
      .o_cur_col     (cur_col),
      .o_wrdata      (wrdata),
      .o_wradr       (wradr),
      .o_wren        (wren)
   );

   logic [28:0] exp_q[$];
   int n_tests  = 0;
   int n_fail   = 0;
   int n_writes = 0;
   int m_pos    = 0;  // model cursor as linear cell index row*COLS+col

   function automatic logic [12:0] cell_adr(input int p);
      return 13'((p / COLS) * 64 + (p % COLS));
   endfunction

   function automatic logic [15:0] cell_word(input logic [2:0] bc, input logic [2:0] fc,
                                             input logic [7:0] ch);
      return {1'b0, bc, 1'b0, fc, ch};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_clear();
      for (int i = 0; i < CELLS; i++) exp_q.push_back({cell_adr(i), cell_word(bcolor, fcolor, 8'h20)});
   endtask

   task automatic model(input logic v, input logic [7:0] ch, input logic sp,
                        input int prow, input int pcol);
      if (sp) m_pos = ((prow > ROWS - 1) ? ROWS - 1 : prow) * COLS + ((pcol > COLS - 1) ? COLS - 1 : pcol);
      if (v) begin
         case (ch)
            8'h0D: m_pos = m_pos - (m_pos % COLS);
            8'h0A: m_pos = ((m_pos / COLS + 1) % ROWS) * COLS;
            8'h08: begin
               if (m_pos > 0) m_pos--;
               exp_q.push_back({cell_adr(m_pos), cell_word(bcolor, fcolor, 8'h20)});
            end
            8'h0C: begin
               push_clear();
               m_pos = 0;
            end
            default: begin
               exp_q.push_back({cell_adr(m_pos), cell_word(bcolor, fcolor, ch)});
               m_pos = (m_pos + 1) % CELLS;
            end
         endcase
      end
   endtask

   // Monitor: every DUT write must match the oldest predicted write.
   always @(negedge clk) begin
      if (wren === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got adr %h data %h, required no write", wradr, wrdata);
         end else begin
            check("write", {3'b0, wradr, wrdata}, {3'b0, exp_q.pop_front()});
         end
      end
   end

   task automatic wait_ready();
      int g = 0;
      while (ch_ready !== 1'b1 && g < 3000) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (ch_ready !== 1'b1) check("ready_timeout", 32'(ch_ready), 32'd1);
   endtask

   // Called aligned at posedge+1; leaves the bench aligned at posedge+1.
   task automatic send(input logic v, input logic [7:0] ch, input logic sp,
                       input int prow, input int pcol);
      wait_ready();
      ch_valid = v;
      ch_data  = ch;
      set_pos  = sp;
      pos_row  = 5'(prow);
      pos_col  = 6'(pcol);
      model(v, ch, sp, prow, pcol);
      @(posedge clk);
      #1;
      ch_valid = 1'b0;
      set_pos  = 1'b0;
      check("cur_row", 32'(cur_row), 32'(m_pos / COLS));
      check("cur_col", 32'(cur_col), 32'(m_pos % COLS));
   endtask

   task automatic wait_drain();
      int g = 0;
      while (exp_q.size() > 0 && g < 3000) begin
         @(posedge clk);
         #1;
         g++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int base;
      int g;
      int r;
      logic [7:0] b;

      // Reset: outputs idle, then a full clear sweep.
      push_clear();
      repeat (3) @(posedge clk);
      #1;
      check("rst_wren", 32'(wren), 32'd0);
      check("rst_wradr", 32'(wradr), 32'd0);
      check("rst_wrdata", 32'(wrdata), 32'd0);
      check("rst_ready", 32'(ch_ready), 32'd0);
      reset_n = 1'b1;
      wait_drain();
      check("post_clear_ready", 32'(ch_ready), 32'd1);
      check("post_clear_row", 32'(cur_row), 32'd0);
      check("post_clear_col", 32'(cur_col), 32'd0);

      // Directed cases.
      fcolor = 3'b010;
      bcolor = 3'b001;
      send(1'b1, 8'h41, 1'b0, 0, 0);
      send(1'b1, 8'h5A, 1'b1, 29, 39);
      send(1'b0, 8'h00, 1'b1, 5, 0);
      send(1'b1, 8'h08, 1'b0, 0, 0);
      send(1'b0, 8'h00, 1'b1, 0, 0);
      send(1'b1, 8'h08, 1'b0, 0, 0);
      send(1'b0, 8'h00, 1'b1, 3, 7);
      send(1'b1, 8'h48, 1'b0, 0, 0);
      send(1'b1, 8'h49, 1'b0, 0, 0);
      send(1'b1, 8'h0D, 1'b0, 0, 0);
      send(1'b1, 8'h0A, 1'b0, 0, 0);
      send(1'b1, 8'h51, 1'b1, 31, 63);
      send(1'b1, 8'h0A, 1'b1, 29, 5);
      wait_drain();

      // FF interrupted by reset after 600 writes: clear must restart from cell 0.
      fcolor = 3'b111;
      bcolor = 3'b100;
      send(1'b1, 8'h0C, 1'b0, 0, 0);
      check("clear_ready_low", 32'(ch_ready), 32'd0);
      base = n_writes;
      g = 0;
      while (n_writes - base < 600 && g < 3000) begin
         @(negedge clk);
         #1;
         g++;
      end
      check("clear_reached_600", 32'(n_writes - base >= 600), 32'd1);
      reset_n = 1'b0;
      exp_q.delete();
      push_clear();
      m_pos = 0;
      @(posedge clk);
      #1;
      check("mid_clear_rst_wren", 32'(wren), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      wait_drain();
      check("restart_ready", 32'(ch_ready), 32'd1);

      // Randomized traffic with back-to-back bytes and idle gaps.
      for (int i = 0; i < 400; i++) begin
         wait_ready();
         fcolor = 3'($urandom);
         bcolor = 3'($urandom);
         r = $urandom_range(0, 99);
         b = 8'($urandom_range(32, 255));
         if (r < 8) b = 8'h0D;
         else if (r < 16) b = 8'h0A;
         else if (r < 26) b = 8'h08;
         else if (r < 27) b = 8'h0C;
         if (r >= 27 && r < 35)
            send(1'b0, 8'h00, 1'b1, $urandom_range(0, 31), $urandom_range(0, 63));
         else
            send(1'b1, b, ($urandom_range(0, 9) == 0), $urandom_range(0, 31), $urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      wait_ready();
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      n_tests++;
      n_fail++;
      $display("FAIL global_timeout: simulation time %0t exceeded", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
